// File: rtl/prim_ram_1p_arb_scrub.sv
// prim_ram_1p_arb_scrub: two-host round-robin SRAM arbiter with background ECC scrubber
module prim_ram_1p_arb_scrub #(
  parameter int Depth = 512,
  parameter int Width = 32,
  parameter int ReadLatency = 1,
  parameter int ScrubInterval = 1024,
  localparam int Aw = (Depth > 1) ? $clog2(Depth) : 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             a_req_i,
  output logic             a_gnt_o,
  input  logic             a_write_i,
  input  logic [Aw-1:0]    a_addr_i,
  input  logic [Width-1:0] a_wdata_i,
  output logic             a_rvalid_o,
  output logic [Width-1:0] a_rdata_o,
  output logic [1:0]       a_rerror_o,
  input  logic             b_req_i,
  output logic             b_gnt_o,
  input  logic             b_write_i,
  input  logic [Aw-1:0]    b_addr_i,
  input  logic [Width-1:0] b_wdata_i,
  output logic             b_rvalid_o,
  output logic [Width-1:0] b_rdata_o,
  output logic [1:0]       b_rerror_o,
  input  logic             scrub_en_i,
  output logic             ram_req_o,
  output logic             ram_write_o,
  output logic [Aw-1:0]    ram_addr_o,
  output logic [Width-1:0] ram_wdata_o,
  output logic [Width-1:0] ram_wmask_o,
  input  logic             ram_rvalid_i,
  input  logic [Width-1:0] ram_rdata_i,
  input  logic [1:0]       ram_rerror_i,
  output logic             scrub_corr_o,
  output logic             scrub_uncorr_o,
  output logic             scrub_done_o
);
  typedef enum logic [1:0] {IDLE, RD, WAIT, WB} state_e;
  localparam int Tw = $clog2(ScrubInterval);
  localparam logic [Tw-1:0] Reload = Tw'(ScrubInterval - 1);
  localparam logic [1:0] TagA = 2'd1, TagB = 2'd2, TagS = 2'd3;
  state_e state_q;
  logic [Tw-1:0] timer_q;
  logic [Aw-1:0] scrub_addr_q;
  logic [Width-1:0] wb_data_q;
  logic hazard_q, rr_q, corr_q, uncorr_q, done_q;
  logic [3:0][1:0] tag_q;
  logic [1:0] wptr_q, rptr_q, grace_q, push_tag, head;
  logic [2:0] cnt_q;
  logic wb_gnt, rd_gnt, a_gnt, b_gnt, push, pop, a_sel, b_sel, resp_s, host_hit, cancel, leave, wrap;
  // WB beats both hosts; hosts share by round-robin; scrub reads only fill idle slots
  assign wb_gnt = !rst_i && state_q == WB;
  assign a_gnt = !rst_i && state_q != WB && a_req_i && (!b_req_i || !rr_q);
  assign b_gnt = !rst_i && state_q != WB && b_req_i && (!a_req_i || rr_q);
  assign rd_gnt = !rst_i && state_q == RD && scrub_en_i && !a_req_i && !b_req_i;
  assign a_gnt_o = a_gnt;
  assign b_gnt_o = b_gnt;
  assign ram_req_o = a_gnt | b_gnt | rd_gnt | wb_gnt;
  assign ram_write_o = wb_gnt | (a_gnt & a_write_i) | (b_gnt & b_write_i);
  assign ram_addr_o = (wb_gnt || rd_gnt) ? scrub_addr_q : a_gnt ? a_addr_i : b_gnt ? b_addr_i : '0;
  assign ram_wdata_o = wb_gnt ? wb_data_q : a_gnt ? a_wdata_i : b_gnt ? b_wdata_i : '0;
  assign ram_wmask_o = '1;
  assign push = (a_gnt & !a_write_i) | (b_gnt & !b_write_i) | rd_gnt;
  assign push_tag = rd_gnt ? TagS : a_gnt ? TagA : TagB;
  assign pop = ram_rvalid_i && cnt_q != '0;
  assign head = tag_q[rptr_q];
  assign a_sel = pop && head == TagA;
  assign b_sel = pop && head == TagB;
  assign resp_s = pop && head == TagS;
  assign a_rvalid_o = a_sel;
  assign b_rvalid_o = b_sel;
  assign a_rdata_o = a_sel ? ram_rdata_i : '0;
  assign b_rdata_o = b_sel ? ram_rdata_i : '0;
  assign a_rerror_o = a_sel ? ram_rerror_i : '0;
  assign b_rerror_o = b_sel ? ram_rerror_i : '0;
  assign host_hit = state_q == WAIT && ((a_gnt && a_write_i && a_addr_i == scrub_addr_q) ||
                                        (b_gnt && b_write_i && b_addr_i == scrub_addr_q));
  assign cancel = hazard_q | host_hit;
  assign leave = (state_q == WAIT && resp_s && !(ram_rerror_i == 2'b01 && !cancel)) || state_q == WB;
  assign wrap = leave && scrub_addr_q == Aw'(Depth - 1);
  assign scrub_corr_o = corr_q;
  assign scrub_uncorr_o = uncorr_q;
  assign scrub_done_o = done_q;
  // Round-robin pointer: after a grant, favour the other host (1 = favour B)
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) rr_q <= 1'b0;
    else if (a_gnt || b_gnt) rr_q <= a_gnt;
  // In-order tag FIFO routing each read response back to its issuer
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      tag_q <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q <= '0;
    end else begin
      if (push) tag_q[wptr_q] <= push_tag;
      wptr_q <= wptr_q + {1'b0, push};
      rptr_q <= rptr_q + {1'b0, pop};
      cnt_q <= cnt_q + {2'b0, push} - {2'b0, pop};
    end
  // Post-reset window in which stale responses from dropped reads may still land
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) grace_q <= 2'(ReadLatency);
    else if (grace_q != '0) grace_q <= grace_q - 2'd1;
  // Scrub FSM with interval timer, address walker and event pulses
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      state_q <= IDLE;
      timer_q <= Reload;
      scrub_addr_q <= '0;
      wb_data_q <= '0;
      hazard_q <= 1'b0;
      corr_q <= 1'b0;
      uncorr_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      corr_q <= 1'b0;
      uncorr_q <= 1'b0;
      done_q <= wrap;
      if (leave) scrub_addr_q <= wrap ? '0 : scrub_addr_q + Aw'(1);
      case (state_q)
        IDLE: if (scrub_en_i) begin
          state_q <= timer_q == '0 ? RD : IDLE;
          timer_q <= timer_q == '0 ? Reload : timer_q - Tw'(1);
        end
        RD: state_q <= !scrub_en_i ? IDLE : rd_gnt ? WAIT : RD;
        WAIT: begin
          if (host_hit) hazard_q <= 1'b1;
          if (resp_s) begin
            hazard_q <= 1'b0;
            corr_q <= ram_rerror_i == 2'b01;
            uncorr_q <= ram_rerror_i[1];
            wb_data_q <= ram_rdata_i;
            state_q <= (ram_rerror_i == 2'b01 && !cancel) ? WB : IDLE;
          end
        end
        WB: state_q <= IDLE;
      endcase
    end
  orphan_rvalid: assert property (@(posedge clk_i) disable iff (rst_i)
    !(ram_rvalid_i && cnt_q == '0 && grace_q == '0));
endmodule
